// File: rtl/serdes_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serdes_tx_pkg
// Description : Shared types and helpers for the transmit-side driver.
//               tx_state_e  - driver state (idle / transmitting)
//               nrz_sym()   - NRZ symbol for a data bit (+1.0 / -1.0)
//               C_*_DEFAULT - default swing and de-emphasis values
// Revision    : 1.0 - initial release
// ============================================================================
package serdes_tx_pkg;

  typedef enum logic [0:0] {
    TX_IDLE   = 1'b0,
    TX_ACTIVE = 1'b1
  } tx_state_e;

  localparam real C_V_SWING_DEFAULT = 1.0;
  localparam real C_DEEMPH_DEFAULT  = 0.25;

  function automatic real nrz_sym(input logic b);
    return b ? 1.0 : -1.0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ui_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : ui_phase_counter
// Description : Sample-phase counter within one unit interval.
//               clk, rst_n - clock, asynchronous active-low reset
//               load       - restart at phase 0 (takes priority over run)
//               run        - advance one sample
//               phase      - current sample index inside the UI
//               last       - phase is the final sample of the UI
// Revision    : 1.0 - initial release
// ============================================================================
module ui_phase_counter #(
  parameter int SAMPLES_PER_UI = 32,
  localparam int C_PHASE_W = (SAMPLES_PER_UI > 1) ? $clog2(SAMPLES_PER_UI) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 run,
  output logic [C_PHASE_W-1:0] phase,
  output logic                 last
);

  localparam logic [C_PHASE_W-1:0] C_LAST_PHASE = C_PHASE_W'(SAMPLES_PER_UI - 1);

  logic [C_PHASE_W-1:0] r_phase;
  logic                 w_last;

  assign w_last = (r_phase == C_LAST_PHASE);

  // The counter parks on the last sample; only load brings it back to 0, so
  // a non-power-of-two UI length never relies on natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (load) begin
      r_phase <= '0;
    end else if (run && !w_last) begin
      r_phase <= r_phase + C_PHASE_W'(1);
    end
  end

  assign phase = r_phase;
  assign last  = w_last;

endmodule
`default_nettype wire

// File: rtl/tx_ffe_driver.sv
`default_nettype none
// ============================================================================
// Module      : tx_ffe_driver
// Description : NRZ line driver with 2-tap post-cursor de-emphasis. Accepts
//               one bit per UI over valid/ready and holds the resulting level
//               for SAMPLES_PER_UI sample clocks.
//               clk, rst_n - sample clock, asynchronous active-low reset
//               enable     - permit starting / continuing transmission
//               bit_in     - data bit, qualified by bit_valid
//               bit_ready  - bit is accepted this cycle (combinational)
//               tx_out     - registered line level (volts)
//               ui_strobe  - pulse on the first sample of each UI
//               active     - driver is transmitting
//               underflow  - sticky: no data at a UI boundary while enabled
// Revision    : 1.0 - initial release
// ============================================================================
module tx_ffe_driver
  import serdes_tx_pkg::*;
#(
  parameter int  SAMPLES_PER_UI = 32,
  parameter real V_SWING        = C_V_SWING_DEFAULT,
  parameter real DEEMPH         = C_DEEMPH_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  output real  tx_out,
  output logic ui_strobe,
  output logic active,
  output logic underflow
);

  localparam int C_PHASE_W = (SAMPLES_PER_UI > 1) ? $clog2(SAMPLES_PER_UI) : 1;
  localparam logic [C_PHASE_W-1:0] C_LAST_PHASE = C_PHASE_W'(SAMPLES_PER_UI - 1);

  tx_state_e            r_state;
  real                  r_sym;       // symbol of the UI on the line, 0.0 when idle
  real                  r_tx_out;
  logic                 r_ui_strobe;
  logic                 r_underflow;

  logic [C_PHASE_W-1:0] w_phase;
  logic                 w_last;
  logic                 w_accept;
  logic                 w_boundary;
  real                  w_level;

  ui_phase_counter #(
    .SAMPLES_PER_UI (SAMPLES_PER_UI)
  ) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_accept || w_boundary),
    .run   (r_state == TX_ACTIVE),
    .phase (w_phase),
    .last  (w_last)
  );

  assign bit_ready  = enable && ((r_state == TX_IDLE) || (w_phase == C_LAST_PHASE));
  assign w_accept   = bit_valid && bit_ready;
  assign w_boundary = (r_state == TX_ACTIVE) && w_last;

  // r_sym is cleared whenever the driver goes idle, so it doubles as the
  // post-cursor tap: the first bit after idle comes out at full swing.
  assign w_level = V_SWING * (nrz_sym(bit_in) - DEEMPH * r_sym);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= TX_IDLE;
      r_sym       <= 0.0;
      r_tx_out    <= 0.0;
      r_ui_strobe <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_ui_strobe <= w_accept;
      if (w_accept) begin
        r_state  <= TX_ACTIVE;
        r_sym    <= nrz_sym(bit_in);
        r_tx_out <= w_level;
      end else if (w_boundary) begin
        // UI ended without a new bit: stop; only a data gap while enabled
        // is an underflow, dropping enable is a clean stop.
        r_state  <= TX_IDLE;
        r_sym    <= 0.0;
        r_tx_out <= 0.0;
        if (enable && !bit_valid) begin
          r_underflow <= 1'b1;
        end
      end
    end
  end

  assign tx_out    = r_tx_out;
  assign ui_strobe = r_ui_strobe;
  assign active    = (r_state == TX_ACTIVE);
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: doc/tx_ffe_driver.md
Name: tx_ffe_driver

Overview:
- Transmit-side line driver that feeds the channel model from the serial bit stream.
- Accepts one bit per unit interval (UI) over a valid/ready handshake and holds it for SAMPLES_PER_UI sample clocks.
- Drives a real-valued NRZ level with 2-tap de-emphasis (FFE). This pre-shapes the signal that the receive-side high-pass equalizer later sharpens.

Parameters:
- SAMPLES_PER_UI, 32, integer sample clocks per UI; legal range 1 or more.
- V_SWING, 1.0, real peak NRZ amplitude, in volts.
- DEEMPH, 0.25, real post-cursor de-emphasis coefficient; legal range 0.0 to 1.0 (0.0 disables the FFE).

Ports:
- clk  input  1  sample clock, one tick per sample period T.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  allows the driver to start or continue transmitting.
- bit_in  input  1  data bit.
- bit_valid  input  1  bit_in is valid.
- bit_ready  output  1  driver accepts bit_in this cycle.
- tx_out  output  real  driven line level.
- ui_strobe  output  1  one-cycle pulse on the first sample of each UI.
- active  output  1  high while in TX_ACTIVE.
- underflow  output  1  sticky flag: data missing at a UI boundary while enabled.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All state is updated on posedge clk.
- Reset values:
  - state = TX_IDLE, phase = 0, s_prev = 0.0.
  - tx_out = 0.0, bit_ready = 0, ui_strobe = 0, active = 0, underflow = 0.
- Symbol mapping: bit 1 maps to s = +1.0; bit 0 maps to s = -1.0.
- Output level: tx_out = V_SWING * (s[n] - DEEMPH * s_prev).
  - Transition: ±V_SWING*(1+DEEMPH).
  - Repeated bit: ±V_SWING*(1-DEEMPH).
  - First bit after idle: s_prev = 0.0, so the level is ±V_SWING.
- tx_out is registered. It stays constant for all SAMPLES_PER_UI cycles of a UI.
- bit_ready is combinational:
  - TX_IDLE: bit_ready = enable.
  - TX_ACTIVE: bit_ready = enable && (phase == SAMPLES_PER_UI-1).
- Accept: a bit is accepted when bit_valid && bit_ready. On the next edge:
  - tx_out is updated with the new level.
  - phase goes to 0, ui_strobe = 1, state = TX_ACTIVE.
  - s_prev takes the symbol of the UI that just ended (0.0 when coming from idle).
- Latency: a bit accepted in cycle k appears on tx_out from cycle k+1 through cycle k+SAMPLES_PER_UI.
- TX_ACTIVE with phase < SAMPLES_PER_UI-1: phase increments; tx_out holds; ui_strobe = 0.
- Boundary cycle (phase == SAMPLES_PER_UI-1) in TX_ACTIVE with no accept; on the next edge:
  - state = TX_IDLE, tx_out = 0.0, s_prev = 0.0, phase = 0.
  - If enable = 1 and bit_valid = 0, underflow is set. It stays set until reset.
  - If enable = 0, this is a clean stop and underflow is not set.
- enable deasserted mid-UI: the current UI completes in full, then the driver stops. No truncation.
- TX_IDLE with no accept: all outputs hold their idle values.
- SAMPLES_PER_UI == 1:
  - phase is always 0.
  - bit_ready = enable in both states.
  - ui_strobe is high on every accepted cycle.
- active = (state == TX_ACTIVE), registered.
- Reset asserted mid-UI: all outputs immediately take their reset values (asynchronous). The in-flight bit is discarded.
- phase counter width: $clog2(SAMPLES_PER_UI), minimum 1 bit. Wrap happens only through the accept/boundary logic, never by natural overflow.

Decomposition:
- Package serdes_tx_pkg:
  - Enum tx_state_e with values TX_IDLE and TX_ACTIVE.
  - Function nrz_sym(bit) returning a real.
  - Default constants for V_SWING and DEEMPH.
- Sub-module ui_phase_counter:
  - Parameter: SAMPLES_PER_UI.
  - Inputs: clk, rst_n, load (restart at 0), run.
  - Outputs: phase, last (phase == SAMPLES_PER_UI-1).
- The FSM and level computation stay in tx_ffe_driver.

Test Plan:
- Reset release, enable = 0 for 100 cycles -> tx_out = 0.0, bit_ready = 0, active = 0, ui_strobe never pulses.
- Defaults; enable = 1; bit_valid held high; bits 1,1,0,0,1 -> tx_out = 1.0, 0.75, -1.25, -0.75, 1.25, each held exactly 32 cycles. ui_strobe pulses every 32 cycles. bit_ready pulses one cycle before each strobe.
- Stream 1,0 then drop bit_valid at the boundary with enable = 1 -> tx_out = 0.0 the next cycle, underflow = 1 (sticky). Next bit 0 gives tx_out = -1.0 (no de-emphasis).
- Drop enable at phase 10 of a UI -> that UI continues to phase 31, then tx_out = 0.0, active = 0, underflow stays 0.
- SAMPLES_PER_UI = 1, DEEMPH = 0.0, alternating bits -> tx_out toggles ±1.0 every cycle, ui_strobe constant 1.
- Assert rst_n = 0 at phase 5 of an active UI -> tx_out = 0.0 and active = 0 within the same cycle. After release, first bit gives ±1.0.
